// File: rtl/main_memory.sv
// Line-granular backing store below the I/D caches; serves one request at a time, d before i.
// Writes respond REQ_DELAY cycles after acceptance, reads REQ_DELAY+RESP_DELAY; requesters hold valid until their pulse.
module main_memory #(
  parameter int MEM_DEPTH  = 1 << 15,
  parameter int REQ_DELAY  = 5,
  parameter int RESP_DELAY = 5,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_resp_valid,
  output logic [LINE_WIDTH-1:0] i_resp_data,
  input  logic                  d_req_valid,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [LINE_WIDTH-1:0] d_req_wdata,
  output logic                  d_resp_valid,
  output logic [LINE_WIDTH-1:0] d_resp_data,
  output logic [1:0]            resp_xcpt,
  output logic                  busy
);

  localparam int LINES   = MEM_DEPTH / 4;
  localparam int IDX_W   = $clog2(LINES);
  localparam int CNT_MAX = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] NO_XCPT      = 2'd0;
  localparam logic [1:0] ADDR_INVALID = 2'd1;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_port_d;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_i_data;
  logic [LINE_WIDTH-1:0] r_d_data;
  logic [LINE_WIDTH-1:0] r_mem [LINES];

  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_req_last;
  logic                  w_resp_last;
  logic                  w_wr_pulse;
  logic                  w_rd_pulse;
  logic [LINE_WIDTH-1:0] w_rd_line;

  // Out-of-range lines alias onto a real index, so every array access is gated by w_oor.
  assign w_word      = r_addr >> 2;
  assign w_idx       = IDX_W'(r_addr >> 4);
  assign w_oor       = (w_word >= ADDR_WIDTH'(MEM_DEPTH));
  assign w_req_last  = (r_cnt == CNT_W'(REQ_DELAY - 1));
  assign w_resp_last = (r_cnt == CNT_W'(RESP_DELAY - 1));
  assign w_wr_pulse  = (r_state == S_REQ) && w_req_last && r_we;
  assign w_rd_pulse  = (r_state == S_RESP) && w_resp_last;
  assign w_rd_line   = w_oor ? '0 : r_mem[w_idx];

  assign busy         = (r_state != S_IDLE);
  assign i_resp_valid = w_rd_pulse && !r_port_d;
  assign d_resp_valid = (w_wr_pulse || w_rd_pulse) && r_port_d;
  assign i_resp_data  = r_i_data;
  assign d_resp_data  = w_wr_pulse ? '0 : r_d_data;
  assign resp_xcpt    = ((w_wr_pulse || w_rd_pulse) && w_oor) ? ADDR_INVALID : NO_XCPT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_port_d <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_i_data <= '0;
      r_d_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (d_req_valid) begin
            r_port_d <= 1'b1;
            r_we     <= d_req_we;
            r_addr   <= d_req_addr;
            r_wdata  <= d_req_wdata;
            r_cnt    <= '0;
            r_state  <= S_REQ;
          end else if (i_req_valid) begin
            r_port_d <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= i_req_addr;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_req_last) begin
            r_cnt <= '0;
            if (r_we) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_RESP;
              if (r_port_d) r_d_data <= w_rd_line;
              else          r_i_data <= w_rd_line;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (w_resp_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Array is deliberately not reset; a reset mid-access leaves r_state idle so no write fires.
  always_ff @(posedge clk) begin
    if (w_wr_pulse && !w_oor) r_mem[w_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: vector table, hand-written timing sequences, randomized ops vs. a line model.
module tb_main_memory;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_req_valid;
  logic [31:0]  i_req_addr;
  logic         i_resp_valid;
  logic [127:0] i_resp_data;
  logic         d_req_valid;
  logic         d_req_we;
  logic [31:0]  d_req_addr;
  logic [127:0] d_req_wdata;
  logic         d_resp_valid;
  logic [127:0] d_resp_data;
  logic [1:0]   resp_xcpt;
  logic         busy;

  always #5 clk = ~clk;

  main_memory #(.MEM_DEPTH(1 << 15), .REQ_DELAY(5), .RESP_DELAY(5), .LINE_WIDTH(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .resp_xcpt(resp_xcpt), .busy(busy)
  );

  localparam logic [1:0] NO_XCPT = 2'd0;
  localparam logic [1:0] ADDR_INV = 2'd1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: one 128-bit entry per line, 8192 lines, word address must be below 1<<15.
  logic [127:0] ref_mem [int];

  function automatic bit ref_oor(input logic [31:0] a);
    return (a >> 2) >= 32'h8000;
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a >> 4) % 8192);
  endfunction

  function automatic logic [127:0] ref_read(input logic [31:0] a);
    if (ref_oor(a)) return '0;
    if (ref_mem.exists(ref_idx(a))) return ref_mem[ref_idx(a)];
    return 'x;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [127:0] d);
    if (!ref_oor(a)) ref_mem[ref_idx(a)] = d;
  endfunction

  // Issue one request from a port; called at posedge+1 with the FSM idle. Returns pulse latency.
  task automatic serve(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [127:0] wdata, output int lat,
                       output logic [127:0] data, output logic [1:0] x);
    int wrong = 0;
    lat = -1; data = 'x; x = 2'b11;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (is_d ? i_resp_valid : d_resp_valid) wrong++;
      if (is_d ? d_resp_valid : i_resp_valid) begin
        lat = n; data = is_d ? d_resp_data : i_resp_data; x = resp_xcpt;
        break;
      end
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0; i_req_valid = 1'b0; d_req_we = 1'b0;
    chk("wrong_port_pulse", 128'(wrong), 128'd0);
  endtask

  // d read at cycle 0, i read raised at cycle i_off; both must complete in priority order.
  task automatic dual(input int i_off, input logic [31:0] i_addr, input logic [31:0] d_addr,
                      input string tag);
    int d_at = -1, i_at = -1, d_cnt = 0, i_cnt = 0;
    logic [127:0] dd = 'x, id = 'x;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = d_addr;
    for (int n = 0; n < 40; n++) begin
      if (n == i_off) begin i_req_valid = 1'b1; i_req_addr = i_addr; end
      @(negedge clk);
      if (n == i_off) chk({tag, "_busy_at_i_raise"}, 128'(busy), 128'(i_off != 0));
      if (d_resp_valid) begin d_cnt++; if (d_at < 0) begin d_at = n; dd = d_resp_data; end end
      if (i_resp_valid) begin i_cnt++; if (i_at < 0) begin i_at = n; id = i_resp_data; end end
      @(posedge clk); #1;
      if (d_at == n) d_req_valid = 1'b0;
      if (i_at == n) break;
    end
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    chk({tag, "_d_lat"}, 128'(d_at), 128'd10);
    chk({tag, "_i_lat"}, 128'(i_at), 128'd21);
    chk({tag, "_d_pulses"}, 128'(d_cnt), 128'd1);
    chk({tag, "_i_pulses"}, 128'(i_cnt), 128'd1);
    chk({tag, "_d_data"}, dd, ref_read(d_addr));
    chk({tag, "_i_data"}, id, ref_read(i_addr));
  endtask

  typedef struct {
    bit           is_d;
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_data;
    logic [1:0]   exp_x;
    int           exp_lat;
  } vec_t;

  localparam logic [127:0] D1 = 128'h1234_5678_90AB_CDEF_1234_5678_90AB_CDEF;
  localparam logic [127:0] D2 = 128'hA5A5_0000_FFFF_1111_2222_3333_4444_5A5A;
  localparam logic [127:0] D3 = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
  localparam logic [127:0] D4 = 128'hC0DE_C0DE_1000_1000_C0DE_C0DE_1000_1000;
  localparam logic [127:0] D5 = 128'hDA7A_4010_DA7A_4010_DA7A_4010_DA7A_4010;
  localparam logic [127:0] D6 = 128'h0DD0_4040_0DD0_4040_0DD0_4040_0DD0_4040;
  localparam logic [127:0] D7 = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [127:0] D8 = 128'hFFFF_FFF0_EEEE_EEE0_DDDD_DDD0_CCCC_CCC0;
  localparam logic [127:0] D9 = 128'h9999_8888_7777_6666_5555_4444_3333_2222;

  vec_t vecs[$];

  initial begin
    int lat;
    logic [127:0] data;
    logic [1:0] x;
    logic [31:0] a;
    logic [127:0] wd;
    bit we;

    vecs = '{
      '{1, 1, 32'h0000_0000, D3, '0, NO_XCPT, 5},
      '{1, 1, 32'h0000_1000, D4, '0, NO_XCPT, 5},
      '{1, 1, 32'h0000_4010, D5, '0, NO_XCPT, 5},
      '{1, 1, 32'h0000_4040, D6, '0, NO_XCPT, 5},
      '{1, 1, 32'h0000_4000, D1, '0, NO_XCPT, 5},
      '{1, 0, 32'h0000_4000, '0, D1, NO_XCPT, 10},
      '{1, 1, 32'h0000_4020, D2, '0, NO_XCPT, 5},
      '{1, 0, 32'h0000_402C, '0, D2, NO_XCPT, 10},
      '{1, 0, 32'h0002_0000, '0, '0, ADDR_INV, 10},
      '{1, 1, 32'h0002_0000, D7, '0, ADDR_INV, 5},
      '{1, 0, 32'h0000_0000, '0, D3, NO_XCPT, 10},
      '{1, 0, 32'h0000_400F, '0, D1, NO_XCPT, 10},
      '{0, 0, 32'h0000_1000, '0, D4, NO_XCPT, 10},
      '{1, 1, 32'h0001_FFF0, D8, '0, NO_XCPT, 5},
      '{0, 0, 32'h0001_FFFC, '0, D8, NO_XCPT, 10},
      '{0, 0, 32'h0002_0004, '0, '0, ADDR_INV, 10}
    };

    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_i_valid", 128'(i_resp_valid), 128'd0);
    chk("rst_d_valid", 128'(d_resp_valid), 128'd0);
    chk("rst_i_data", i_resp_data, 128'd0);
    chk("rst_d_data", d_resp_data, 128'd0);
    chk("rst_xcpt", 128'(resp_xcpt), 128'(NO_XCPT));
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[k]) begin
      serve(vecs[k].is_d, vecs[k].we, vecs[k].addr, vecs[k].wdata, lat, data, x);
      if (vecs[k].we) ref_write(vecs[k].addr, vecs[k].wdata);
      chk($sformatf("vec%0d_lat", k), 128'(lat), 128'(vecs[k].exp_lat));
      chk($sformatf("vec%0d_data", k), data, vecs[k].exp_data);
      chk($sformatf("vec%0d_xcpt", k), 128'(x), 128'(vecs[k].exp_x));
    end
    chk("xcpt_idle", 128'(resp_xcpt), 128'(NO_XCPT));

    dual(0, 32'h0000_1000, 32'h0000_4010, "arb");
    dual(4, 32'h0000_1000, 32'h0000_4000, "stall");

    // Reset in the middle of a write: no response, old line survives.
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h0000_4040; d_req_wdata = D9;
    begin
      int pulses = 0;
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        if (d_resp_valid || i_resp_valid) pulses++;
        if (n == 3) begin rst_n = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0; end
        if (n == 5) rst_n = 1'b1;
      end
      chk("rstmid_no_pulse", 128'(pulses), 128'd0);
      chk("rstmid_busy", 128'(busy), 128'd0);
      chk("rstmid_d_data", d_resp_data, 128'd0);
      chk("rstmid_i_data", i_resp_data, 128'd0);
    end
    @(posedge clk); #1;
    serve(1, 0, 32'h0000_4040, '0, lat, data, x);
    chk("rstmid_old_lat", 128'(lat), 128'd10);
    chk("rstmid_old_data", data, D6);

    // Randomized: seed a pool of lines, then mixed reads/writes on both ports vs. the model.
    for (int k = 0; k < 16; k++) begin
      a = 32'h0000_8000 + 32'(k * 16);
      wd = {$urandom, $urandom, $urandom, $urandom};
      serve(1, 1, a, wd, lat, data, x);
      ref_write(a, wd);
      chk($sformatf("seed%0d_lat", k), 128'(lat), 128'd5);
    end
    for (int k = 0; k < 40; k++) begin
      bit use_d;
      use_d = $urandom_range(0, 2) != 0;
      we = use_d && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) a = 32'h0002_0000 + 32'($urandom_range(0, 32'hFFFF));
      else a = 32'h0000_8000 + 32'($urandom_range(0, 15) * 16) + 32'($urandom_range(0, 15));
      wd = {$urandom, $urandom, $urandom, $urandom};
      serve(use_d, we, a, wd, lat, data, x);
      chk($sformatf("rnd%0d_lat", k), 128'(lat), we ? 128'd5 : 128'd10);
      chk($sformatf("rnd%0d_data", k), data, we ? 128'd0 : ref_read(a));
      chk($sformatf("rnd%0d_xcpt", k), 128'(x), ref_oor(a) ? 128'(ADDR_INV) : 128'(NO_XCPT));
      if (we) ref_write(a, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/main_memory.md
# main_memory

Line-granular backing memory with a fixed-latency timing model, sitting directly below the instruction and data caches. It accepts 128-bit cache-line fill (read) and writeback (write) requests from both caches over a valid/response handshake. It arbitrates between them and serves one request at a time. Each access takes `MEM_REQ_DELAY` + `MEM_RESP_DELAY` cycles for reads and `MEM_REQ_DELAY` cycles for writes.

## Interface
Parameters:
- `MEM_DEPTH`, 1<<15, memory size in 32-bit words; number of lines = `MEM_DEPTH`/4.
- `REQ_DELAY`, `MEM_REQ_DELAY` (5), request-phase cycles; must be ≥1.
- `RESP_DELAY`, `MEM_RESP_DELAY` (5), read response-phase cycles; must be ≥1.
- `LINE_WIDTH`, `CACHE_LINE_WIDTH` (128), line width in bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 1: icache line-fill request, held until `i_resp_valid`.
- `i_req_addr` in `ADDRESS_WIDTH`: icache line address; bits [3:0] ignored.
- `i_resp_valid` out 1: one-cycle pulse; `i_resp_data` valid.
- `i_resp_data` out `LINE_WIDTH`: fill data.
- `d_req_valid` in 1: dcache request, held until `d_resp_valid`.
- `d_req_we` in 1: 1 = writeback, 0 = fill.
- `d_req_addr` in `ADDRESS_WIDTH`: dcache line address; bits [3:0] ignored.
- `d_req_wdata` in `LINE_WIDTH`: writeback data.
- `d_resp_valid` out 1: one-cycle pulse; read data valid, or write complete.
- `d_resp_data` out `LINE_WIDTH`: fill data (0 for writes).
- `resp_xcpt` out 2 (`xcpt_e`): qualifies the current response pulse; `NO_XCPT` or `ADDR_INVALID`.
- `busy` out 1: FSM not in IDLE.

## Operation
- States: IDLE, REQ, RESP.
- IDLE:
  - Samples requests. `d_req_valid` has fixed priority over `i_req_valid`.
  - The winner's port id, address, `we` and wdata are latched. The loser stays pending, since its valid is held.
  - Moves to REQ with the counter set to 0.
- REQ:
  - The counter increments each cycle. On the last cycle (counter = `REQ_DELAY`-1) the array is accessed.
  - Read: the line is latched into the response register, then the FSM moves to RESP with the counter cleared.
  - Write: the line is written, the selected `*_resp_valid` pulses in this same cycle, and the FSM returns to IDLE.
- RESP:
  - The counter increments each cycle.
  - On the last cycle (counter = `RESP_DELAY`-1) the selected `*_resp_valid` pulses with the data, and the FSM returns to IDLE.
- Array indexing:
  - Line index = addr[`$clog2(MEM_DEPTH/4)`+3:4].
  - An address with addr[31:2] ≥ `MEM_DEPTH` is out of range. It gives `resp_xcpt`=`ADDR_INVALID`, read data 0, and the write is dropped. Timing is unchanged.
- Requester rule: deassert valid in the cycle after the response pulse, unless a new request is intended. Valid seen in IDLE is always treated as a new request.
- Requests arriving while busy are not sampled; they are served later in priority order.
- Response data registers hold their last value between pulses. `resp_xcpt` is `NO_XCPT` outside pulses.

## Timing
- Request accepted in IDLE at cycle t:
  - Write response pulses in cycle t+`REQ_DELAY` (t+5).
  - Read response pulses in cycle t+`REQ_DELAY`+`RESP_DELAY` (t+10).
- The FSM is back in IDLE in the cycle after the pulse. The next request is accepted at the earliest then, giving one turnaround cycle.
- Back-to-back reads: throughput is one line per `REQ_DELAY`+`RESP_DELAY`+1 cycles.
- A read sees a write that completed in any earlier cycle, since accesses are strictly serialized.
- Reset (asynchronous, any state including mid-access):
  - State → IDLE, counter → 0, latched request cleared.
  - `i_resp_valid`=0, `d_resp_valid`=0, `i_resp_data`=0, `d_resp_data`=0, `resp_xcpt`=`NO_XCPT`, `busy`=0.
  - The in-flight request is abandoned with no response; a write not yet performed is lost.
  - Array contents are not reset.
- Simultaneous i and d valid in IDLE: d is served first. i is accepted in the cycle after d's response pulse, if still valid.

## Test plan
- Write then read: d write of line 0x1234…CDEF to 0x4000 is accepted at cycle t → `d_resp_valid` at t+5. A d read of 0x4000 accepted at t+6 → `d_resp_valid` at t+16 with the same 128-bit data and `resp_xcpt`=`NO_XCPT`.
- Arbitration: i read 0x1000 and d read 0x4010 are raised in the same cycle t → `d_resp_valid` at t+10, `i_resp_valid` at t+21, with no pulse on the wrong port.
- Offset bits ignored: write to 0x4020, then read 0x402C → the data written to 0x4020 is returned.
- Out-of-range: read at 0x00020000 (word 0x8000 ≥ `MEM_DEPTH`) → pulse at t+10 with data 0 and `resp_xcpt`=`ADDR_INVALID`. A write to the same address pulses at t+5 and leaves all lines unchanged.
- Reset mid-access: assert `rst_n`=0 at t+3 of a d write to 0x4040, release at t+5 → no response, `busy`=0, and a subsequent read of 0x4040 returns the old content.
- Stall handling: `i_req_valid` raised while a d access is busy (cycle t+4) → not accepted until the d pulse at t+10; accepted at t+11, `i_resp_valid` at t+21.
